// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory bus between the instruction-fetch port and the data port.
// It grants one request per cycle. An in-order tag FIFO records which port
// issued each outstanding read, so each response goes back to the right port.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration. When it
// is undefined, the arbiter uses fixed priority with data ahead of instruction.
module mem_port_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_req_addr,
  input  logic        data_req_wr,
  input  logic [3:0]  data_req_be,
  input  logic [31:0] data_req_wdata,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wr,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_err
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic             lock_q;
  logic             owner_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             tag_mem [MAX_OUT];
  logic             rsp_err_q;

  logic fifo_empty;
  logic pop;
  logic push;
  logic room;
  logic instr_elig;
  logic data_elig;
  logic sel;
  logic sel_valid;
  logic accept;
  logic head_tag;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_q;
`endif

  // FIFO status and eligibility: a read needs a free tag slot, or a slot freed by a pop this cycle
  always_comb begin
    fifo_empty = (count_q == '0);
    pop        = mem_rsp_valid & ~fifo_empty & ~reset;
    room       = (count_q < MAX_CNT) | pop;
    instr_elig = instr_req_valid & room;
    data_elig  = data_req_valid & (data_req_wr | room);
  end

  // Source selection: a locked owner holds the bus, otherwise arbitrate among eligible requesters
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel       = owner_q;
      sel_valid = owner_q ? data_req_valid : instr_req_valid;
    end else if (instr_elig && data_elig) begin
`ifdef MEM_ARB_RR_EN
      sel       = rr_ptr_q;
`else
      sel       = 1'b1;
`endif
      sel_valid = 1'b1;
    end else if (data_elig) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end else if (instr_elig) begin
      sel       = 1'b0;
      sel_valid = 1'b1;
    end
  end

  // Request mux and handshake; everything is forced low while reset is held
  always_comb begin
    mem_req_valid   = sel_valid & ~reset;
    accept          = mem_req_valid & mem_req_ready;
    instr_req_ready = accept & ~sel;
    data_req_ready  = accept & sel;
    mem_req_addr    = sel ? data_req_addr : instr_req_addr;
    mem_req_wr      = sel & data_req_wr;
    mem_req_be      = sel ? data_req_be : 4'hF;
    mem_req_wdata   = sel ? data_req_wdata : 32'h0;
    push            = accept & (~sel | ~data_req_wr);
  end

  // Response routing by the tag at the FIFO head; data goes to both ports
  always_comb begin
    head_tag        = tag_mem[rd_ptr_q];
    instr_rsp_valid = pop & ~head_tag;
    data_rsp_valid  = pop & head_tag;
    instr_rsp_data  = mem_rsp_data;
    data_rsp_data   = mem_rsp_data;
    rsp_err         = rsp_err_q & ~reset;
  end

  // Lock register keeps a stalled request stable until the bus accepts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else if (mem_req_valid && !mem_req_ready) begin
      lock_q  <= 1'b1;
      owner_q <= sel;
    end else if (accept) begin
      lock_q  <= 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer hands priority to the other port after every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= ~sel;
    end
  end
`endif

  // Tag FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Tag storage; entries are only read while the FIFO holds them, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= sel;
  end

  // Sticky error flag for a response that arrives with no read outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (mem_rsp_valid && fifo_empty) begin
      rsp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed test of mem_port_arbiter with hand-computed expectations.
// Expectations for contention follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_req_addr;
  logic        data_req_wr;
  logic [3:0]  data_req_be;
  logic [31:0] data_req_wdata;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_err;

  int assertCount = 0;
  int failCount   = 0;

  mem_port_arbiter #(.MAX_OUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req_valid (instr_req_valid),
    .instr_req_ready (instr_req_ready),
    .instr_req_addr  (instr_req_addr),
    .instr_rsp_valid (instr_rsp_valid),
    .instr_rsp_data  (instr_rsp_data),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_addr   (data_req_addr),
    .data_req_wr     (data_req_wr),
    .data_req_be     (data_req_be),
    .data_req_wdata  (data_req_wdata),
    .data_rsp_valid  (data_rsp_valid),
    .data_rsp_data   (data_rsp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wr      (mem_req_wr),
    .mem_req_be      (mem_req_be),
    .mem_req_wdata   (mem_req_wdata),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .rsp_err         (rsp_err)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and record the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive every input for one cycle, then let the combinational paths settle
  task automatic applyStimulus(input logic iv, input logic [31:0] iaddr,
                               input logic dv, input logic [31:0] daddr, input logic dwr,
                               input logic rdy, input logic rv, input logic [31:0] rdata);
    instr_req_valid = iv;
    instr_req_addr  = iaddr;
    data_req_valid  = dv;
    data_req_addr   = daddr;
    data_req_wr     = dwr;
    data_req_be     = 4'hA;
    data_req_wdata  = 32'hDEADBEEF;
    mem_req_ready   = rdy;
    mem_rsp_valid   = rv;
    mem_rsp_data    = rdata;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over one rising edge with idle inputs
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    reset = 1'b1;
    applyStimulus(1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h55);
    checkOutput("rst_mem_req_valid", mem_req_valid, 0);
    checkOutput("rst_instr_ready", instr_req_ready, 0);
    checkOutput("rst_data_ready", data_req_ready, 0);
    checkOutput("rst_instr_rsp_valid", instr_rsp_valid, 0);
    checkOutput("rst_data_rsp_valid", data_rsp_valid, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    nextCycle();
    doReset();

    // Single fetch followed by its response
    applyStimulus(1, 32'h100, 0, 0, 0, 1, 0, 0);
    checkOutput("fetch_mem_valid", mem_req_valid, 1);
    checkOutput("fetch_mem_addr", mem_req_addr, 32'h100);
    checkOutput("fetch_instr_ready", instr_req_ready, 1);
    checkOutput("fetch_mem_wr", mem_req_wr, 0);
    checkOutput("fetch_mem_be", mem_req_be, 32'hF);
    checkOutput("fetch_mem_wdata", mem_req_wdata, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h002081B3);
    checkOutput("fetch_rsp_valid", instr_rsp_valid, 1);
    checkOutput("fetch_rsp_data", instr_rsp_data, 32'h002081B3);
    checkOutput("fetch_data_rsp_valid", data_rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("fetch_no_err", rsp_err, 0);

    // Contention: instruction read against data write every cycle
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h400 + i, 1, 32'h500 + i, 1, 1, 0, 0);
`ifdef MEM_ARB_RR_EN
      checkOutput($sformatf("cont%0d_instr_ready", i), instr_req_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont%0d_data_ready", i), data_req_ready, (i % 2 == 0) ? 0 : 1);
      checkOutput($sformatf("cont%0d_addr", i), mem_req_addr, (i % 2 == 0) ? 32'h400 + i : 32'h500 + i);
`else
      checkOutput($sformatf("cont%0d_instr_ready", i), instr_req_ready, 0);
      checkOutput($sformatf("cont%0d_data_ready", i), data_req_ready, 1);
      checkOutput($sformatf("cont%0d_addr", i), mem_req_addr, 32'h500 + i);
      checkOutput($sformatf("cont%0d_be", i), mem_req_be, 32'hA);
      checkOutput($sformatf("cont%0d_wdata", i), mem_req_wdata, 32'hDEADBEEF);
`endif
      nextCycle();
    end

    // Backpressure lock: stalled data read holds the bus while instr arrives
    doReset();
    applyStimulus(0, 0, 1, 32'h200, 0, 0, 0, 0);
    checkOutput("lock0_addr", mem_req_addr, 32'h200);
    checkOutput("lock0_valid", mem_req_valid, 1);
    checkOutput("lock0_data_ready", data_req_ready, 0);
    nextCycle();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 32'h104, 1, 32'h200, 0, 0, 0, 0);
      checkOutput($sformatf("lock%0d_addr", i), mem_req_addr, 32'h200);
      checkOutput($sformatf("lock%0d_instr_ready", i), instr_req_ready, 0);
      nextCycle();
    end
    applyStimulus(1, 32'h104, 1, 32'h200, 0, 1, 0, 0);
    checkOutput("lock3_data_ready", data_req_ready, 1);
    checkOutput("lock3_instr_ready", instr_req_ready, 0);
    checkOutput("lock3_addr", mem_req_addr, 32'h200);
    nextCycle();
    applyStimulus(1, 32'h104, 0, 0, 0, 1, 0, 0);
    checkOutput("lock4_instr_ready", instr_req_ready, 1);
    checkOutput("lock4_addr", mem_req_addr, 32'h104);
    nextCycle();

    // Ordering and full FIFO
    doReset();
    applyStimulus(1, 32'h10, 0, 0, 0, 1, 0, 0);
    checkOutput("ord0_instr_ready", instr_req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 1, 32'h20, 0, 1, 0, 0);
    checkOutput("ord1_data_ready", data_req_ready, 1);
    nextCycle();
    applyStimulus(0, 0, 1, 32'h24, 0, 1, 0, 0);
    checkOutput("ord2_data_ready", data_req_ready, 1);
    nextCycle();
    applyStimulus(1, 32'h14, 0, 0, 0, 1, 0, 0);
    checkOutput("ord3_instr_ready", instr_req_ready, 1);
    nextCycle();
    applyStimulus(1, 32'h18, 1, 32'h300, 1, 1, 0, 0);
    checkOutput("full_instr_ready", instr_req_ready, 0);
    checkOutput("full_write_ready", data_req_ready, 1);
    checkOutput("full_write_addr", mem_req_addr, 32'h300);
    checkOutput("full_write_wr", mem_req_wr, 1);
    nextCycle();
    applyStimulus(1, 32'h18, 1, 32'h28, 0, 1, 0, 0);
    checkOutput("full_blocked_valid", mem_req_valid, 0);
    checkOutput("full_blocked_data", data_req_ready, 0);
    nextCycle();
    applyStimulus(1, 32'h18, 0, 0, 0, 1, 1, 32'hA1);
    checkOutput("pop0_instr_rsp", instr_rsp_valid, 1);
    checkOutput("pop0_data_rsp", data_rsp_valid, 0);
    checkOutput("pop0_grant", instr_req_ready, 1);
    checkOutput("pop0_addr", mem_req_addr, 32'h18);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hA2);
    checkOutput("pop1_data_rsp", data_rsp_valid, 1);
    checkOutput("pop1_data", data_rsp_data, 32'hA2);
    checkOutput("pop1_instr_rsp", instr_rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hA3);
    checkOutput("pop2_data_rsp", data_rsp_valid, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hA4);
    checkOutput("pop3_instr_rsp", instr_rsp_valid, 1);
    checkOutput("pop3_data_rsp", data_rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hA5);
    checkOutput("pop4_instr_rsp", instr_rsp_valid, 1);
    checkOutput("pop4_err", rsp_err, 0);
    nextCycle();

    // Spurious response with an empty FIFO
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hBAD);
    checkOutput("spur_instr_rsp", instr_rsp_valid, 0);
    checkOutput("spur_data_rsp", data_rsp_valid, 0);
    checkOutput("spur_err_same", rsp_err, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("spur_err_next", rsp_err, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("spur_err_sticky", rsp_err, 1);
    nextCycle();

    // Reset in the middle of operation with two reads outstanding
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("midrst_err_clear", rsp_err, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 1, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 32'h44, 0, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 32'h48, 1, 32'h4C, 0, 1, 1, 32'h77);
    reset = 1'b1;
    #1;
    checkOutput("midrst_mem_valid", mem_req_valid, 0);
    checkOutput("midrst_instr_ready", instr_req_ready, 0);
    checkOutput("midrst_data_ready", data_req_ready, 0);
    checkOutput("midrst_instr_rsp", instr_rsp_valid, 0);
    checkOutput("midrst_data_rsp", data_rsp_valid, 0);
    checkOutput("midrst_err", rsp_err, 0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h78);
    checkOutput("postrst_instr_rsp", instr_rsp_valid, 0);
    checkOutput("postrst_data_rsp", data_rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("postrst_err", rsp_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
